// File: rtl/mesh_pkt_injector.sv
// ============================================================================
// Module   : mesh_pkt_injector
// Purpose  : Traffic source for one mesh router P port; FIFO-buffered packets
//            carrying source, sequence payload and a fixed or swept destination.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_pkt_injector #(
    parameter int x_cord_width_p = 2,
    parameter int y_cord_width_p = 2,
    parameter int data_width_p   = 4,
    parameter int fifo_els_p     = 4,
    parameter int count_width_p  = 8,
    localparam int cord_width_lp = x_cord_width_p + y_cord_width_p,
    localparam int pkt_width_lp  = 2*cord_width_lp + data_width_p
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      start_i,
    input  logic [count_width_p-1:0]  num_pkts_i,
    input  logic [1:0]                mode_i,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    output logic                      v_o,
    output logic [pkt_width_lp-1:0]   data_o,
    input  logic                      yumi_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  sent_count_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GEN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_SWEEP      = 2'd1;
    localparam logic [1:0] MODE_SWEEP_SKIP = 2'd2;

    logic [1:0]               state_q,    state_d;
    logic [count_width_p-1:0] num_pkts_q, num_pkts_d;
    logic [count_width_p-1:0] seq_q,      seq_d;
    logic [count_width_p-1:0] sent_q,     sent_d;
    logic [1:0]               mode_q,     mode_d;
    logic [cord_width_lp-1:0] dest_q,     dest_d;
    logic [ptr_w_lp-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [ptr_w_lp-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [cnt_w_lp-1:0]      count_q,    count_d;
    logic [pkt_width_lp-1:0]  mem_q [fifo_els_p];

    logic [cord_width_lp-1:0] self_cord;
    logic [cord_width_lp-1:0] dest_inc;
    logic [cord_width_lp-1:0] dest_adv;
    logic [cord_width_lp-1:0] start_dest;
    logic [pkt_width_lp-1:0]  push_data;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic                     sweep;
    logic                     skip_self;

    // {y,x} concatenation makes the sweep a plain increment of the linear index
    assign self_cord  = {my_y_i, my_x_i};
    assign sweep      = (mode_q == MODE_SWEEP) || (mode_q == MODE_SWEEP_SKIP);
    assign skip_self  = (mode_q == MODE_SWEEP_SKIP);
    assign dest_inc   = dest_q + 1'b1;
    assign dest_adv   = (skip_self && (dest_inc == self_cord)) ? (dest_q + 2'd2) : dest_inc;
    assign start_dest = ((mode_i == MODE_SWEEP_SKIP) && ({dest_y_i, dest_x_i} == self_cord))
                        ? ({dest_y_i, dest_x_i} + 1'b1) : {dest_y_i, dest_x_i};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == cnt_w_lp'(fifo_els_p));
    assign pop        = yumi_i && !fifo_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign push       = (state_q == ST_GEN) && (!fifo_full || pop);
    assign push_data  = {self_cord, seq_q[data_width_p-1:0], dest_q};

    always_comb begin
        state_d    = state_q;
        num_pkts_d = num_pkts_q;
        seq_d      = seq_q;
        sent_d     = sent_q;
        mode_d     = mode_q;
        dest_d     = dest_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            seq_d    = seq_q + 1'b1;
            if (sweep) begin
                dest_d = dest_adv;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            sent_d   = sent_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    num_pkts_d = num_pkts_i;
                    mode_d     = mode_i;
                    dest_d     = start_dest;
                    seq_d      = '0;
                    sent_d     = '0;
                    state_d    = (num_pkts_i == '0) ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                if (push && ((seq_q + 1'b1) == num_pkts_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            num_pkts_q <= '0;
            seq_q      <= '0;
            sent_q     <= '0;
            mode_q     <= '0;
            dest_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            num_pkts_q <= num_pkts_d;
            seq_q      <= seq_d;
            sent_q     <= sent_d;
            mode_q     <= mode_d;
            dest_q     <= dest_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the occupancy count alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign v_o          = !fifo_empty;
    assign data_o       = mem_q[rd_ptr_q];
    assign busy_o       = (state_q == ST_GEN) || (state_q == ST_DRAIN);
    assign done_o       = (state_q == ST_DONE);
    assign sent_count_o = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_mesh_pkt_injector.sv
// ============================================================================
// Module   : tb_mesh_pkt_injector
// Purpose  : Directed self-checking bench for mesh_pkt_injector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_pkt_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  my_x, my_y;
    logic        start;
    logic [7:0]  num_pkts;
    logic [1:0]  mode;
    logic [1:0]  dest_x, dest_y;
    logic        v;
    logic [11:0] data;
    logic        yumi;
    logic        busy, done;
    logic [7:0]  sent;

    int errors = 0;
    int checks = 0;
    logic [11:0] got[$];
    int first_cyc, last_cyc;

    mesh_pkt_injector dut (
        .clk          (clk),
        .reset        (reset),
        .my_x_i       (my_x),
        .my_y_i       (my_y),
        .start_i      (start),
        .num_pkts_i   (num_pkts),
        .mode_i       (mode),
        .dest_x_i     (dest_x),
        .dest_y_i     (dest_y),
        .v_o          (v),
        .data_o       (data),
        .yumi_i       (yumi),
        .busy_o       (busy),
        .done_o       (done),
        .sent_count_o (sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (yumi && !v) begin
            errors++;
            $display("FAIL yumi_without_valid: yumi=1 v_o=%0b", v);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pk(input logic [1:0] sy, input logic [1:0] sx,
                                       input logic [3:0] p, input logic [1:0] dy,
                                       input logic [1:0] dx);
        return {sy, sx, p, dy, dx};
    endfunction

    task automatic start_run(input logic [1:0] m, input logic [1:0] dx,
                             input logic [1:0] dy, input logic [7:0] n);
        @(negedge clk);
        mode = m; dest_x = dx; dest_y = dy; num_pkts = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes packets as soon as they are valid; ends on the negedge after the last pop
    task automatic collect(input int n, input int budget);
        got.delete();
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < budget && got.size() < n; c++) begin
            @(negedge clk);
            if (v) begin
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                got.push_back(data);
                yumi = 1'b1;
            end else begin
                yumi = 1'b0;
            end
        end
        @(negedge clk);
        yumi = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({v, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: v/busy/done=%b required 000", {v, busy, done});
        end
        checks++;
        if (sent !== 8'd0) begin
            errors++;
            $display("FAIL reset_sent: got %0d required 0", sent);
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed;
        start_run(2'd0, 2'd3, 2'd2, 8'd3);
        checks++;
        if ({busy, v, done} !== 3'b100) begin
            errors++;
            $display("FAIL fixed_after_start: busy/v/done=%b required 100", {busy, v, done});
        end
        collect(3, 20);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL fixed_count: got %0d packets required 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3)) begin
                errors++;
                $display("FAIL fixed_pkt%0d: got %h required %h", i,
                         (i < got.size()) ? got[i] : 12'hxxx, pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3));
            end
        end
        checks++;
        if (first_cyc != 0) begin
            errors++;
            $display("FAIL fixed_latency: first valid at cycle %0d required 0", first_cyc);
        end
        checks++;
        if ({done, busy, v} !== 3'b100 || sent !== 8'd3) begin
            errors++;
            $display("FAIL fixed_done: done/busy/v=%b sent=%0d required 100 sent=3",
                     {done, busy, v}, sent);
        end
    endtask

    task automatic test_backpressure;
        yumi = 1'b0;
        start_run(2'd0, 2'd3, 2'd2, 8'd6);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (v !== 1'b1 || data !== pk(2'd0, 2'd1, 4'd0, 2'd2, 2'd3)) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b data=%h required v=1 data=%h", k, v, data,
                         pk(2'd0, 2'd1, 4'd0, 2'd2, 2'd3));
            end
        end
        checks++;
        if ({busy, done} !== 2'b10 || sent !== 8'd0) begin
            errors++;
            $display("FAIL bp_stalled: busy/done=%b sent=%0d required 10 sent=0", {busy, done}, sent);
        end
        collect(6, 30);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3)) begin
                errors++;
                $display("FAIL bp_pkt%0d: got %h required %h", i,
                         (i < got.size()) ? got[i] : 12'hxxx, pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3));
            end
        end
        checks++;
        if (last_cyc - first_cyc != 5) begin
            errors++;
            $display("FAIL bp_throughput: span %0d cycles required 5", last_cyc - first_cyc);
        end
        checks++;
        if (done !== 1'b1 || sent !== 8'd6) begin
            errors++;
            $display("FAIL bp_done: done=%b sent=%0d required done=1 sent=6", done, sent);
        end
    endtask

    task automatic test_sweep_skip;
        logic [3:0] exp_d [5];
        exp_d = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
        start_run(2'd2, 2'd0, 2'd0, 8'd5);
        collect(5, 30);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size() ||
                got[i] !== pk(2'd0, 2'd1, 4'(i), exp_d[i][3:2], exp_d[i][1:0])) begin
                errors++;
                $display("FAIL sweep_pkt%0d: got %h required %h", i,
                         (i < got.size()) ? got[i] : 12'hxxx,
                         pk(2'd0, 2'd1, 4'(i), exp_d[i][3:2], exp_d[i][1:0]));
            end
        end
        checks++;
        if (done !== 1'b1 || sent !== 8'd5) begin
            errors++;
            $display("FAIL sweep_done: done=%b sent=%0d required done=1 sent=5", done, sent);
        end
        // start destination equal to self is advanced before the first push
        start_run(2'd2, 2'd1, 2'd0, 8'd1);
        collect(1, 10);
        checks++;
        if (got.size() != 1 || got[0] !== pk(2'd0, 2'd1, 4'd0, 2'd0, 2'd2)) begin
            errors++;
            $display("FAIL sweep_self_start: got %h required %h",
                     (got.size() > 0) ? got[0] : 12'hxxx, pk(2'd0, 2'd1, 4'd0, 2'd0, 2'd2));
        end
    endtask

    task automatic test_zero_pkts;
        logic saw_v;
        start_run(2'd0, 2'd0, 2'd0, 8'd0);
        checks++;
        if ({done, busy, v} !== 3'b100 || sent !== 8'd0) begin
            errors++;
            $display("FAIL zero_done: done/busy/v=%b sent=%0d required 100 sent=0",
                     {done, busy, v}, sent);
        end
        saw_v = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (v) saw_v = 1'b1;
        end
        checks++;
        if (saw_v !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_valid: saw v_o=%b required 0", saw_v);
        end
    endtask

    task automatic test_reset_mid;
        yumi = 1'b0;
        start_run(2'd0, 2'd3, 2'd2, 8'd6);
        repeat (2) @(negedge clk);
        checks++;
        if (v !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: v=%b busy=%b required 1 1", v, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({v, busy, done} !== 3'b000 || sent !== 8'd0) begin
            errors++;
            $display("FAIL midreset_flush: v/busy/done=%b sent=%0d required 000 sent=0",
                     {v, busy, done}, sent);
        end
        reset = 1'b0;
        start_run(2'd0, 2'd3, 2'd2, 8'd2);
        collect(2, 20);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3)) begin
                errors++;
                $display("FAIL midreset_pkt%0d: got %h required %h", i,
                         (i < got.size()) ? got[i] : 12'hxxx, pk(2'd0, 2'd1, 4'(i), 2'd2, 2'd3));
            end
        end
        checks++;
        if (done !== 1'b1 || sent !== 8'd2) begin
            errors++;
            $display("FAIL midreset_done: done=%b sent=%0d required done=1 sent=2", done, sent);
        end
    endtask

    task automatic test_restart;
        start_run(2'd0, 2'd2, 2'd2, 8'd1);
        checks++;
        if (sent !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: sent=%0d busy=%b done=%b required 0 1 0", sent, busy, done);
        end
        collect(1, 10);
        checks++;
        if (got.size() != 1 || got[0] !== pk(2'd0, 2'd1, 4'd0, 2'd2, 2'd2)) begin
            errors++;
            $display("FAIL restart_pkt: got %h required %h",
                     (got.size() > 0) ? got[0] : 12'hxxx, pk(2'd0, 2'd1, 4'd0, 2'd2, 2'd2));
        end
        checks++;
        if (sent !== 8'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: sent=%0d done=%b required sent=1 done=1", sent, done);
        end
    endtask

    initial begin
        reset    = 1'b1;
        my_x     = 2'd1;
        my_y     = 2'd0;
        start    = 1'b0;
        num_pkts = 8'd0;
        mode     = 2'd0;
        dest_x   = 2'd0;
        dest_y   = 2'd0;
        yumi     = 1'b0;

        test_reset;
        test_fixed;
        test_backpressure;
        test_sweep_skip;
        test_zero_pkts;
        test_reset_mid;
        test_restart;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
